// File: rtl/pir_motion_conditioner.sv
// PIR motion conditioner: synchronises, debounces, warm-up gates and hold-extends the
// raw sensor output, and keeps a frame-aligned copy for the colour stage.
module pir_motion_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 148500,
  parameter int HOLD_CYCLES     = 297000000,
  parameter int WARMUP_CYCLES   = 148500000,
  parameter int CNT_W           = 8
) (
  input  logic             clk_148_mhz,
  input  logic             rst_n,
  input  logic             motion_raw,
  input  logic             frame_start,
  input  logic             clear_count,
  output logic             motion_level,
  output logic             motion_active,
  output logic             motion_display,
  output logic             motion_rise,
  output logic [CNT_W-1:0] event_count,
  output logic             warmup_done
);

  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {WARMUP, IDLE, ACTIVE, HOLD} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_in;
  logic [DEB_W-1:0]       deb_cnt;
  logic [WARM_W-1:0]      warm_cnt;
  logic [HOLD_W-1:0]      hold_cnt;
  logic                   warm_last;
  logic                   hold_last;
  logic                   new_event;

  assign sync_in   = sync_ff[SYNC_STAGES-1];
  assign warm_last = (warm_cnt == WARM_LAST);
  assign hold_last = (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk_148_mhz) begin
    if (!rst_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], motion_raw};
    end
  end

  // Level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk_148_mhz) begin
    if (!rst_n) begin
      deb_cnt      <= '0;
      motion_level <= 1'b0;
    end else if (sync_in != motion_level) begin
      if (deb_cnt == DEB_LAST) begin
        deb_cnt      <= '0;
        motion_level <= ~motion_level;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  always_comb begin
    state_next = state;
    new_event  = 1'b0;
    case (state)
      WARMUP: begin
        if (warm_last) begin
          state_next = motion_level ? ACTIVE : IDLE;
          new_event  = motion_level;
        end
      end
      IDLE: begin
        if (motion_level) begin
          state_next = ACTIVE;
          new_event  = 1'b1;
        end
      end
      ACTIVE: begin
        if (!motion_level) state_next = HOLD;
      end
      HOLD: begin
        // A retrigger takes priority over an expiry in the same cycle.
        if (motion_level)   state_next = ACTIVE;
        else if (hold_last) state_next = IDLE;
      end
      default: state_next = WARMUP;
    endcase
  end

  always_ff @(posedge clk_148_mhz) begin
    if (!rst_n) begin
      state         <= WARMUP;
      warm_cnt      <= '0;
      hold_cnt      <= '0;
      warmup_done   <= 1'b0;
      motion_active <= 1'b0;
      motion_rise   <= 1'b0;
    end else begin
      state         <= state_next;
      motion_active <= (state_next == ACTIVE) || (state_next == HOLD);
      motion_rise   <= new_event;
      if (state == WARMUP && !warm_last) warm_cnt <= warm_cnt + 1'b1;
      if (state == WARMUP && warm_last)  warmup_done <= 1'b1;
      if (state == ACTIVE) begin
        hold_cnt <= '0;
      end else if (state == HOLD && !hold_last) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  // A clear coincident with a new event leaves exactly that event counted.
  always_ff @(posedge clk_148_mhz) begin
    if (!rst_n) begin
      event_count <= '0;
    end else if (clear_count) begin
      event_count <= new_event ? CNT_W'(1) : '0;
    end else if (new_event && event_count != CNT_MAX) begin
      event_count <= event_count + 1'b1;
    end
  end

  always_ff @(posedge clk_148_mhz) begin
    if (!rst_n) begin
      motion_display <= 1'b0;
    end else if (frame_start) begin
      motion_display <= motion_active;
    end
  end

endmodule

// File: doc/pir_motion_conditioner.md
Name: pir_motion_conditioner

Overview:
- Conditions the asynchronous PIR sensor output before the colour stage consumes it.
- Internal pipeline: synchronise, debounce, gate off during sensor warm-up, then extend each detection with a retriggerable hold timer.
- Sits in the 148.5 MHz pixel domain between the Motion_detected pad and the motion/colour logic.
- Outputs include a frame-aligned motion flag so the display colour changes only at frame boundaries.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchroniser stages on motion_raw (min 2).
- DEBOUNCE_CYCLES, 148500, consecutive stable cycles required to accept a level change (1 ms).
- HOLD_CYCLES, 297000000, cycles motion_active stays high after motion_level falls (2 s).
- WARMUP_CYCLES, 148500000, cycles after reset during which detections are ignored (1 s).
- CNT_W, 8, event counter width.

Ports:
- clk_148_mhz  in  1  pixel clock; all logic is on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- motion_raw  in  1  asynchronous PIR output (Motion_detected pad).
- frame_start  in  1  one-cycle pulse at the start of each frame (from the timing generator).
- clear_count  in  1  one-cycle pulse; zeroes event_count.
- motion_level  out  1  synchronised, debounced sensor level.
- motion_active  out  1  hold-extended motion flag.
- motion_display  out  1  motion_active sampled at frame_start.
- motion_rise  out  1  one-cycle pulse per new detection event.
- event_count  out  CNT_W  saturating count of detection events.
- warmup_done  out  1  high once the warm-up period has elapsed.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - all synchroniser flops, motion_level, motion_active, motion_display, motion_rise, event_count and warmup_done go to 0;
  - all counters clear;
  - FSM enters WARMUP.
- Reset asserted mid-operation aborts any hold or debounce in progress with the same result.
- Synchroniser: SYNC_STAGES-deep flop chain; its last stage is sync_in.
- Debounce:
  - deb_cnt increments each cycle that sync_in != motion_level.
  - deb_cnt clears on any cycle where they are equal.
  - When sync_in != motion_level and deb_cnt == DEBOUNCE_CYCLES-1, motion_level toggles on the next edge and deb_cnt clears.
  - Latency: a clean step on motion_raw reaches motion_level after SYNC_STAGES+DEBOUNCE_CYCLES cycles, ±1 cycle for input sampling phase.
  - Glitches shorter than DEBOUNCE_CYCLES are never propagated.
  - The debouncer runs in every FSM state, including WARMUP.
- FSM (states WARMUP, IDLE, ACTIVE, HOLD):
  - WARMUP:
    - warm_cnt counts 0..WARMUP_CYCLES-1; motion_active=0.
    - At terminal count, warmup_done goes to 1 (sticky until reset).
    - Next state is ACTIVE if motion_level=1, otherwise IDLE. This is the start of a new event.
  - IDLE:
    - motion_active=0.
    - motion_level=1 moves to ACTIVE; this is the start of a new event.
  - ACTIVE:
    - motion_active=1.
    - motion_level=0 moves to HOLD and loads hold_cnt=0.
  - HOLD:
    - motion_active=1; hold_cnt increments.
    - motion_level=1 returns to ACTIVE. This is a retrigger: no motion_rise, no count.
    - If hold_cnt == HOLD_CYCLES-1 and motion_level=0, move to IDLE.
    - If retrigger and expiry coincide, retrigger wins.
- New event (registered, same edge as the state change into ACTIVE):
  - motion_rise=1 for exactly one cycle.
  - event_count increments, saturating at 2^CNT_W-1.
- Count clearing:
  - clear_count zeroes event_count on the next edge.
  - If clear_count and a new event occur in the same cycle, event_count becomes 1.
- motion_active is a registered decode of the state, high in ACTIVE and HOLD.
- motion_display:
  - On a cycle where frame_start=1, motion_display loads motion_active on the next edge.
  - Otherwise it holds its value.
  - If frame_start never arrives, motion_display stays 0.
- Counter widths are $clog2 of each parameter; no counter ever wraps.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, WARMUP_CYCLES=8, CNT_W=8.

- Reset then idle:
  - rst_n low 3 cycles, then high, motion_raw=0.
  - All outputs 0; warmup_done rises at cycle 8 after release; FSM in IDLE.
- Warm-up masking:
  - After release, motion_raw=1 held from cycle 0.
  - motion_level=1 at about cycle 6; motion_active stays 0 until warm-up ends.
  - Then one motion_rise pulse; event_count=1.
- Glitch rejection:
  - After warm-up, 3-cycle high pulse on motion_raw.
  - motion_level, motion_active, motion_rise stay 0.
  - A 5-cycle pulse instead produces motion_level high for 4–5 cycles, one motion_rise, event_count=1.
- Hold and retrigger:
  - Detection, then motion_raw low.
  - motion_active stays high exactly 10 cycles after motion_level falls.
  - Re-asserting motion_raw during HOLD keeps motion_active continuously high; no second motion_rise; event_count unchanged.
- Saturation and clear:
  - 260 separated events → event_count=255.
  - clear_count pulse → 0.
  - clear_count coincident with an event → 1.
- Frame alignment:
  - motion_active rises mid-frame; motion_display changes only one cycle after the next frame_start pulse.
  - It also falls only at the frame_start following hold expiry.
